psum_accumulator: RTL and testbench
===================================

PSUM_ACCUMULATOR -- requirements
Module: psum_accumulator

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 34, width of the signed MAC result consumed per beat.
REQ-002 SHALL have parameter ACC_WIDTH, default 40, width of the internal signed accumulator.
REQ-003 SHALL have parameter OUT_WIDTH, default 16, width of the signed requantized output.
REQ-004 SHALL have parameter OUTPUT_SCALE, default 0, arithmetic right-shift applied before saturation.
REQ-005 SHALL have parameter MAX_LEN, default 64, maximum number of beats per accumulation.
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 rst_in  input  1  reset, synchronous, active-high.
REQ-008 in_valid  input  1  in_data and len_in valid.
REQ-009 in_ready  output  1  block accepts a beat this cycle.
REQ-010 in_data  input  IN_WIDTH  signed partial sum from the upstream MAC.
REQ-011 len_in  input  $clog2(MAX_LEN+1)  beats in the group; sampled on the first beat only.
REQ-012 out_valid  output  1  out_data/out_sat valid.
REQ-013 out_ready  input  1  downstream accepts the result.
REQ-014 out_data  output  OUT_WIDTH  signed requantized sum.
REQ-015 out_sat  output  1  out_data was clipped.

Function
REQ-016 SHALL implement states IDLE, ACCUM, HOLD; a beat is accepted when in_valid and in_ready are both 1.
REQ-017 IDLE: in_ready=1; a beat loads acc = sign-extended in_data, latches len_in (0 treated as 1), sets count=1, and goes to HOLD if len==1, else ACCUM.
REQ-018 ACCUM: in_ready=1; each beat adds acc += sext(in_data) and count++; the beat making count==len goes to HOLD.
REQ-019 On entering HOLD, out_data/out_sat SHALL be registered from the final sum, with out_valid=1 in the cycle after the last beat (latency 1).
REQ-020 HOLD: in_ready=out_ready, and out_data/out_sat stay stable while out_ready=0.
REQ-021 In HOLD, out_valid&out_ready with in_valid in the same cycle SHALL hand off the result and accept the beat as a new group's first beat (IDLE semantics, no bubble).
REQ-022 In HOLD, out_valid&out_ready without in_valid SHALL go to IDLE, with out_valid=0 next cycle.
REQ-023 Requant: r = acc >>> OUTPUT_SCALE (floor), then clip to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1], with out_sat=1 iff clipped.
REQ-024 Accumulator overflow SHALL wrap modulo 2^ACC_WIDTH, with no flag.

Reset
REQ-025 While rst_in=1: state=IDLE, acc=0, count=0, out_valid=0, out_data=0, out_sat=0, in_ready=0.
REQ-026 Reset mid-group SHALL discard the partial sum; no result is emitted for that group.

Configuration
REQ-027 With PSUM_ROUND_EN defined, requant SHALL add 2^(OUTPUT_SCALE-1) before the shift (round half up), with no effect when OUTPUT_SCALE==0.
REQ-028 Without PSUM_ROUND_EN, requant SHALL be pure floor shift, with no rounding logic.

Structure
REQ-029 Package psum_pkg SHALL hold the state enum and default width constants (IN_WIDTH, ACC_WIDTH, OUT_WIDTH, MAX_LEN).
REQ-030 Combinational shift/round/saturate SHALL live in sub-module psum_requant (in acc, out data+sat).

Verification
REQ-031 With scale 0, len 4, beats 10,20,-5,7 -> out_data=32, out_sat=0, out_valid 1 cycle after the 4th beat.
REQ-032 With len 2, beats 30000,30000 -> out_data=32767, out_sat=1; with -30000,-30000 -> out_data=-32768, out_sat=1.
REQ-033 With OUTPUT_SCALE=4, len 1: input 40 gives 2 without PSUM_ROUND_EN and 3 with it; input -40 gives -3 without it and -2 with it.
REQ-034 With out_ready=0 for 5 cycles in HOLD -> in_ready=0 and out_data stable; then out_ready=1 with in_valid=1 (len 1, data 9) -> old result handed off, and next cycle out_data=9.
REQ-035 With rst_in pulsed after 2 of 4 beats -> out_valid stays 0; next group len 1 with data 5 -> out_data=5 (no residue).
REQ-036 With len_in=0 and data 12 -> treated as len 1, out_data=12 one cycle later.

Source files
------------

// File: rtl/psum_pkg.sv
// psum_pkg: shared definitions for the partial-sum accumulator slice.
//   state_e            accumulator control states (IDLE, ACCUM, HOLD)
//   DEF_*              default widths/limits used as parameter defaults
package psum_pkg;

  localparam int DEF_IN_WIDTH  = 34;
  localparam int DEF_ACC_WIDTH = 40;
  localparam int DEF_OUT_WIDTH = 16;
  localparam int DEF_MAX_LEN   = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/psum_requant.sv
// psum_requant: combinational requantizer.
//   acc      in   signed accumulator value
//   out_data out  acc >>> OUTPUT_SCALE, clipped to the signed OUT_WIDTH range
//   out_sat  out  1 when out_data was clipped
// Build option: define PSUM_ROUND_EN to add 2^(OUTPUT_SCALE-1) before the
// shift (round half up); otherwise the shift is a pure floor.
module psum_requant import psum_pkg::*; #(
  parameter int ACC_WIDTH    = DEF_ACC_WIDTH,
  parameter int OUT_WIDTH    = DEF_OUT_WIDTH,
  parameter int OUTPUT_SCALE = 0
) (
  input  logic signed [ACC_WIDTH-1:0] acc,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic                        out_sat
);

  // One guard bit so the rounding bias cannot overflow the accumulator range.
  localparam int EW = ACC_WIDTH + 1;

  localparam logic signed [EW-1:0] MAX_V =
    {{(EW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [EW-1:0] MIN_V = ~MAX_V;

`ifdef PSUM_ROUND_EN
  localparam int RND_SHIFT = (OUTPUT_SCALE > 0) ? OUTPUT_SCALE - 1 : 0;
  localparam logic signed [EW-1:0] RND = (OUTPUT_SCALE > 0) ? (EW'(1) << RND_SHIFT) : '0;
`endif

  logic signed [EW-1:0] ext;
  logic signed [EW-1:0] biased;
  logic signed [EW-1:0] shifted;

  always_comb begin
    ext = {acc[ACC_WIDTH-1], acc};
`ifdef PSUM_ROUND_EN
    biased = ext + RND;
`else
    biased = ext;
`endif
    shifted  = biased >>> OUTPUT_SCALE;
    out_sat  = 1'b0;
    out_data = shifted[OUT_WIDTH-1:0];
    if (shifted > MAX_V) begin
      out_data = MAX_V[OUT_WIDTH-1:0];
      out_sat  = 1'b1;
    end else if (shifted < MIN_V) begin
      out_data = MIN_V[OUT_WIDTH-1:0];
      out_sat  = 1'b1;
    end
  end

endmodule

// File: rtl/psum_accumulator.sv
// psum_accumulator: accumulates a group of signed MAC partial sums and emits
// one requantized, saturated result per group.
//   clk, rst_in          clock; synchronous active-high reset
//   in_valid/in_ready    beat handshake; in_data signed partial sum,
//                        len_in group length (sampled on the first beat, 0 -> 1)
//   out_valid/out_ready  result handshake; out_data signed result,
//                        out_sat set when out_data was clipped
// Build option: PSUM_ROUND_EN selects round-half-up requantization
// (see psum_requant).
module psum_accumulator import psum_pkg::*; #(
  parameter int IN_WIDTH     = DEF_IN_WIDTH,
  parameter int ACC_WIDTH    = DEF_ACC_WIDTH,
  parameter int OUT_WIDTH    = DEF_OUT_WIDTH,
  parameter int OUTPUT_SCALE = 0,
  parameter int MAX_LEN      = DEF_MAX_LEN,
  localparam int LEN_W       = $clog2(MAX_LEN + 1)
) (
  input  logic                        clk,
  input  logic                        rst_in,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [IN_WIDTH-1:0]  in_data,
  input  logic        [LEN_W-1:0]     len_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic                        out_sat
);

  state_e                       state_q, state_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic        [LEN_W-1:0]      count_q, count_d;
  logic        [LEN_W-1:0]      len_q, len_d;
  logic                         out_valid_q, out_valid_d;
  logic signed [OUT_WIDTH-1:0]  out_data_q, out_data_d;
  logic                         out_sat_q, out_sat_d;

  logic                         accept;
  logic                         start_grp;
  logic                         finish;
  logic signed [ACC_WIDTH-1:0]  beat_ext;
  logic        [LEN_W-1:0]      len_eff;
  logic signed [OUT_WIDTH-1:0]  rq_data;
  logic                         rq_sat;

  // Requantize the next accumulator value so the result can be registered
  // on the same edge that accepts the group's final beat.
  psum_requant #(
    .ACC_WIDTH    (ACC_WIDTH),
    .OUT_WIDTH    (OUT_WIDTH),
    .OUTPUT_SCALE (OUTPUT_SCALE)
  ) u_requant (
    .acc      (acc_d),
    .out_data (rq_data),
    .out_sat  (rq_sat)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    len_d       = len_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    start_grp   = 1'b0;
    finish      = 1'b0;

    beat_ext = ACC_WIDTH'(in_data);
    len_eff  = (len_in == '0) ? LEN_W'(1) : len_in;

    if (rst_in)                in_ready = 1'b0;
    else if (state_q == HOLD)  in_ready = out_ready;
    else                       in_ready = 1'b1;
    accept = in_valid && in_ready;

    unique case (state_q)
      IDLE: start_grp = accept;
      ACCUM: begin
        if (accept) begin
          acc_d   = acc_q + beat_ext;
          count_d = count_q + LEN_W'(1);
          finish  = (count_d == len_q);
        end
      end
      HOLD: begin
        // Handoff; a beat in the same cycle opens the next group directly.
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
          start_grp   = accept;
        end
      end
      default: state_d = IDLE;
    endcase

    if (start_grp) begin
      acc_d   = beat_ext;
      len_d   = len_eff;
      count_d = LEN_W'(1);
      if (len_eff == LEN_W'(1)) finish  = 1'b1;
      else                      state_d = ACCUM;
    end

    if (finish) begin
      state_d     = HOLD;
      out_valid_d = 1'b1;
      out_data_d  = rq_data;
      out_sat_d   = rq_sat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      len_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      len_q       <= len_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// Testbench for psum_accumulator: two instances (OUTPUT_SCALE 0 and 4) share
// one stimulus stream; results are predicted from integer arithmetic on the
// beats of each group. Honors PSUM_ROUND_EN the same way as the design.
module tb_psum_accumulator;

  localparam int IW = 34;
  localparam int AW = 40;
  localparam int OW = 16;
  localparam int ML = 64;
  localparam int LW = $clog2(ML + 1);
`ifdef PSUM_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif
  localparam longint MAXO = (longint'(1) <<< (OW - 1)) - 1;
  localparam longint MINO = -(longint'(1) <<< (OW - 1));

  logic          clk = 1'b0;
  logic          rst_in;
  logic          in_valid;
  logic          out_ready;
  logic [IW-1:0] in_data;
  logic [LW-1:0] len_in;
  logic          in_ready0, out_valid0, out_sat0;
  logic [OW-1:0] out_data0;
  logic          in_ready4, out_valid4, out_sat4;
  logic [OW-1:0] out_data4;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  psum_accumulator #(
    .IN_WIDTH(IW), .ACC_WIDTH(AW), .OUT_WIDTH(OW), .OUTPUT_SCALE(0), .MAX_LEN(ML)
  ) u_s0 (
    .clk(clk), .rst_in(rst_in), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .len_in(len_in), .out_valid(out_valid0),
    .out_ready(out_ready), .out_data(out_data0), .out_sat(out_sat0)
  );

  psum_accumulator #(
    .IN_WIDTH(IW), .ACC_WIDTH(AW), .OUT_WIDTH(OW), .OUTPUT_SCALE(4), .MAX_LEN(ML)
  ) u_s4 (
    .clk(clk), .rst_in(rst_in), .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data), .len_in(len_in), .out_valid(out_valid4),
    .out_ready(out_ready), .out_data(out_data4), .out_sat(out_sat4)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic longint wrap_acc(longint v);
    longint t;
    t = v <<< (64 - AW);
    return t >>> (64 - AW);
  endfunction

  function automatic longint requant(longint acc, int s, output bit sat);
    longint r;
    r = acc;
    if (RND && s > 0) r = r + (longint'(1) <<< (s - 1));
    r = r >>> s;
    sat = 1'b0;
    if (r > MAXO) begin r = MAXO; sat = 1'b1; end
    else if (r < MINO) begin r = MINO; sat = 1'b1; end
    return r;
  endfunction

  function automatic longint rand_beat(bit full);
    longint v;
    if (full) begin
      v = longint'({$urandom, $urandom});
      v = (v <<< (64 - IW)) >>> (64 - IW);
    end else begin
      v = longint'($urandom_range(100000, 0)) - 50000;
    end
    return v;
  endfunction

  task automatic chk(string tag, logic signed [63:0] obs, logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [63:0] sx(logic [OW-1:0] v);
    return 64'($signed(v));
  endfunction

  // Present one beat at a negedge, wait (bounded) for in_ready, and return
  // at the negedge following the accepting edge with in_valid dropped.
  task automatic drive_beat(longint d, int lf);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_data  = d[IW-1:0];
    len_in   = lf[LW-1:0];
    #1;
    while (!in_ready0 && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    chk("beat.in_ready", 64'(in_ready0), 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic expect_result(string tag, longint sum);
    bit s0, s4;
    longint acc, e0, e4;
    acc = wrap_acc(sum);
    e0  = requant(acc, 0, s0);
    e4  = requant(acc, 4, s4);
    chk({tag, ".valid0"}, 64'(out_valid0), 64'd1);
    chk({tag, ".data0"},  sx(out_data0),   e0);
    chk({tag, ".sat0"},   64'(out_sat0),   64'(s0));
    chk({tag, ".valid4"}, 64'(out_valid4), 64'd1);
    chk({tag, ".data4"},  sx(out_data4),   e4);
    chk({tag, ".sat4"},   64'(out_sat4),   64'(s4));
  endtask

  initial begin
    longint sum;
    logic [OW-1:0] held;
    rst_in    = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_data   = '0;
    len_in    = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst.in_ready",  64'(in_ready0),  64'd0);
    chk("rst.out_valid", 64'(out_valid0), 64'd0);
    chk("rst.out_data",  sx(out_data0),   64'd0);
    chk("rst.out_sat",   64'(out_sat0),   64'd0);
    rst_in = 1'b0;
    #1;
    chk("idle.in_ready", 64'(in_ready0), 64'd1);
    @(negedge clk);

    // Four-beat group, latency 1
    drive_beat(10, 4);
    drive_beat(20, 4);
    drive_beat(-5, 4);
    chk("g4.early_valid", 64'(out_valid0), 64'd0);
    drive_beat(7, 4);
    chk("g4.const", sx(out_data0), 64'sd32);
    expect_result("g4", 32);
    @(negedge clk);
    chk("g4.drain", 64'(out_valid0), 64'd0);

    // Saturation both directions
    drive_beat(30000, 2);
    drive_beat(30000, 2);
    chk("satp.const", sx(out_data0), 64'sd32767);
    expect_result("satp", 60000);
    @(negedge clk);
    drive_beat(-30000, 2);
    drive_beat(-30000, 2);
    chk("satn.const", sx(out_data0), -64'sd32768);
    expect_result("satn", -60000);
    @(negedge clk);

    // Scale-4 floor vs rounding
    drive_beat(40, 1);
    chk("s4p.const", sx(out_data4), RND ? 64'sd3 : 64'sd2);
    expect_result("s4p", 40);
    @(negedge clk);
    drive_beat(-40, 1);
    chk("s4n.const", sx(out_data4), RND ? -64'sd2 : -64'sd3);
    expect_result("s4n", -40);
    @(negedge clk);

    // Backpressure in HOLD, then handoff with a same-cycle new beat
    out_ready = 1'b0;
    drive_beat(100, 2);
    drive_beat(200, 2);
    expect_result("bp", 300);
    held = out_data0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp.in_ready", 64'(in_ready0), 64'd0);
      chk("bp.stable",   sx(out_data0),  sx(held));
      chk("bp.valid",    64'(out_valid0), 64'd1);
    end
    out_ready = 1'b1;
    drive_beat(9, 1);
    chk("bp.next_const", sx(out_data0), 64'sd9);
    expect_result("bp.next", 9);
    @(negedge clk);
    chk("bp.drain", 64'(out_valid0), 64'd0);

    // Reset mid-group discards the partial sum
    drive_beat(1000, 4);
    drive_beat(2000, 4);
    rst_in = 1'b1;
    @(negedge clk);
    chk("mid.rst_valid", 64'(out_valid0), 64'd0);
    rst_in = 1'b0;
    @(negedge clk);
    chk("mid.after_valid", 64'(out_valid0), 64'd0);
    drive_beat(5, 1);
    chk("mid.const", sx(out_data0), 64'sd5);
    expect_result("mid", 5);
    @(negedge clk);

    // len_in == 0 behaves as a single beat
    drive_beat(12, 0);
    chk("len0.const", sx(out_data0), 64'sd12);
    expect_result("len0", 12);
    @(negedge clk);

    // Accumulator wrap: 100 max-positive beats exceed the 40-bit range
    sum = 0;
    for (int b = 0; b < 100; b++) begin
      drive_beat((longint'(1) <<< (IW - 1)) - 1, 100);
      sum += (longint'(1) <<< (IW - 1)) - 1;
    end
    expect_result("wrap", sum);
    @(negedge clk);

    // Random groups with gaps, stalls and back-to-back handoff
    for (int g = 0; g < 40; g++) begin
      int lf, n, stall;
      longint d;
      lf  = $urandom_range(8, 0);
      n   = (lf == 0) ? 1 : lf;
      sum = 0;
      for (int b = 0; b < n; b++) begin
        if (b > 0 && $urandom_range(3, 0) == 0) @(negedge clk);
        d = rand_beat(g[0]);
        sum += d;
        drive_beat(d, (b == 0) ? lf : int'($urandom_range(127, 0)));
      end
      expect_result("rand", sum);
      stall = $urandom_range(2, 0);
      if (stall > 0) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
          @(negedge clk);
          chk("rand.in_ready", 64'(in_ready0), 64'd0);
          expect_result("rand.stall", sum);
        end
        out_ready = 1'b1;
      end
      if ($urandom_range(1, 0) == 1) begin
        @(negedge clk);
        chk("rand.drain", 64'(out_valid0), 64'd0);
      end
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
